// File: rtl/j1_io_port.sv
// Memory-mapped I/O peripheral for the J1 I/O bus: sampled input channels with
// change flags, read-back output registers, and debounced switches with press counters.
module j1_io_port #(
    parameter int WIDTH           = 16,
    parameter int NUM_IN          = 2,
    parameter int IN_WIDTH        = 10,
    parameter int NUM_OUT         = 4,
    parameter int OUT_WIDTH       = 8,
    parameter int NUM_SW          = 1,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic                          clk,
    input  logic                          resetq,
    input  logic                          io_wr,
    input  logic                          io_rd,
    input  logic [15:0]                   io_addr,
    input  logic [WIDTH-1:0]              io_dout,
    output logic [WIDTH-1:0]              io_din,
    input  logic [NUM_IN*IN_WIDTH-1:0]    in_data,
    output logic [NUM_OUT*OUT_WIDTH-1:0]  out_data,
    input  logic [NUM_SW-1:0]             sw_in,
    output logic [NUM_SW-1:0]             sw_state
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  DEB_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [IN_WIDTH-1:0]   in_slice [NUM_IN];
    logic [IN_WIDTH-1:0]   samp_q   [NUM_IN];
    logic [IN_WIDTH-1:0]   samp_d   [NUM_IN];
    logic [NUM_IN-1:0]     flag_q, flag_d;
    logic                  flag_clr;

    logic [OUT_WIDTH-1:0]  out_q    [NUM_OUT];
    logic [OUT_WIDTH-1:0]  out_d    [NUM_OUT];

    logic [NUM_SW-1:0]     sync1_q, sync1_d;
    logic [NUM_SW-1:0]     sync2_q, sync2_d;
    logic [NUM_SW-1:0]     sw_state_q, sw_state_d;
    logic [NUM_SW-1:0]     sw_rise, press_clr;
    logic [CW-1:0]         deb_q    [NUM_SW];
    logic [CW-1:0]         deb_d    [NUM_SW];
    logic [7:0]            press_q  [NUM_SW];
    logic [7:0]            press_d  [NUM_SW];

    logic [WIDTH-1:0]      io_din_q, io_din_d;

    // Only the low OUT_WIDTH bits of write data are stored.
    logic                  unused_dout;
    assign unused_dout = ^io_dout;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        assign in_slice[g] = in_data[g*IN_WIDTH +: IN_WIDTH];
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_data[g*OUT_WIDTH +: OUT_WIDTH] = out_q[g];
    end

    assign sw_state = sw_state_q;
    assign io_din   = io_din_q;

    always_comb begin
        io_din_d = '0;
        for (int k = 0; k < NUM_IN; k++)
            if (io_addr == 16'(k)) io_din_d = WIDTH'(samp_q[k]);
        for (int k = 0; k < NUM_OUT; k++)
            if (io_addr == 16'(16 + k)) io_din_d = WIDTH'(out_q[k]);
        if (io_addr == 16'h0020) io_din_d = WIDTH'(sw_state_q);
        for (int k = 0; k < NUM_SW; k++)
            if (io_addr == 16'(33 + k)) io_din_d = WIDTH'(press_q[k]);
        if (io_addr == 16'h0030) io_din_d = WIDTH'(flag_q);
    end

    // A change seen in the same cycle as the clearing read keeps its flag set.
    always_comb begin
        flag_clr = io_rd && (io_addr == 16'h0030);
        flag_d   = flag_q;
        for (int k = 0; k < NUM_IN; k++) begin
            samp_d[k] = in_slice[k];
            flag_d[k] = (flag_clr ? 1'b0 : flag_q[k]) | (in_slice[k] != samp_q[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++)
            out_d[k] = (io_wr && io_addr == 16'(16 + k)) ? io_dout[OUT_WIDTH-1:0] : out_q[k];
    end

    always_comb begin
        sync1_d    = sw_in;
        sync2_d    = sync1_q;
        sw_state_d = sw_state_q;
        sw_rise    = '0;
        press_clr  = '0;
        for (int k = 0; k < NUM_SW; k++) begin
            deb_d[k]   = '0;
            press_d[k] = press_q[k];
            if (sync2_q[k] != sw_state_q[k]) begin
                if (deb_q[k] == DEB_MAX) sw_state_d[k] = sync2_q[k];
                else                     deb_d[k]      = deb_q[k] + CW'(1);
            end
            sw_rise[k]   = !sw_state_q[k] && sw_state_d[k];
            press_clr[k] = io_rd && (io_addr == 16'(33 + k));
            if (press_clr[k])    press_d[k] = sw_rise[k] ? 8'd1 : 8'd0;
            else if (sw_rise[k]) press_d[k] = press_q[k] + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            io_din_q   <= '0;
            flag_q     <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sw_state_q <= '0;
            for (int k = 0; k < NUM_IN; k++)  samp_q[k]  <= '0;
            for (int k = 0; k < NUM_OUT; k++) out_q[k]   <= '0;
            for (int k = 0; k < NUM_SW; k++) begin
                deb_q[k]   <= '0;
                press_q[k] <= '0;
            end
        end else begin
            io_din_q   <= io_din_d;
            flag_q     <= flag_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sw_state_q <= sw_state_d;
            for (int k = 0; k < NUM_IN; k++)  samp_q[k]  <= samp_d[k];
            for (int k = 0; k < NUM_OUT; k++) out_q[k]   <= out_d[k];
            for (int k = 0; k < NUM_SW; k++) begin
                deb_q[k]   <= deb_d[k];
                press_q[k] <= press_d[k];
            end
        end
    end

endmodule

// File: tb/tb_j1_io_port.sv
// Directed bench for j1_io_port with a short debounce window.
module tb_j1_io_port;

    logic        clk = 1'b0;
    logic        resetq;
    logic        io_wr, io_rd;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic [19:0] in_data;
    logic [31:0] out_data;
    logic [0:0]  sw_in;
    logic [0:0]  sw_state;

    int checks = 0;
    int errors = 0;
    int rise_cyc;

    j1_io_port #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .resetq(resetq), .io_wr(io_wr), .io_rd(io_rd),
        .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
        .in_data(in_data), .out_data(out_data), .sw_in(sw_in), .sw_state(sw_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        io_addr = a; io_dout = d; io_wr = 1'b1;
        step();
        io_wr = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic r, input logic [31:0] exp, input string tag);
        io_addr = a; io_rd = r;
        step();
        io_rd = 1'b0;
        chk(tag, 32'(io_din), exp);
    endtask

    task automatic press();
        sw_in = 1'b1;
        repeat (8) step();
        sw_in = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        resetq = 1'b0; io_wr = 1'b0; io_rd = 1'b0; io_addr = '0; io_dout = '0;
        in_data = '0; sw_in = 1'b0;
        repeat (2) step();
        resetq = 1'b1;

        // 1: build up state, then asynchronous reset
        wr(16'h0010, 16'h0055);
        sw_in = 1'b1;
        repeat (10) step();
        in_data = {10'h123, 10'h000};
        step();
        io_addr = 16'h0010;
        step();
        chk("pre_out", out_data, 32'h0000_0055);
        chk("pre_sw", 32'(sw_state), 32'h1);
        chk("pre_din", 32'(io_din), 32'h0055);
        #2 resetq = 1'b0;
        #1;
        chk("rst_out", out_data, 32'h0);
        chk("rst_sw", 32'(sw_state), 32'h0);
        chk("rst_din", 32'(io_din), 32'h0);
        sw_in = 1'b0; in_data = '0;
        repeat (2) step();
        resetq = 1'b1;
        rd(16'h0010, 1'b0, 32'h0, "rst_rd10");
        rd(16'h0011, 1'b0, 32'h0, "rst_rd11");
        rd(16'h0012, 1'b0, 32'h0, "rst_rd12");
        rd(16'h0013, 1'b0, 32'h0, "rst_rd13");
        rd(16'h0020, 1'b0, 32'h0, "rst_rd20");
        rd(16'h0021, 1'b0, 32'h0, "rst_rd21");
        rd(16'h0030, 1'b0, 32'h0, "rst_rd30");

        // 2: output registers and decode
        wr(16'h0011, 16'h00A5);
        wr(16'h0013, 16'h003C);
        wr(16'h0010, 16'h01FF);
        chk("out_pack", out_data, 32'h3C00_A5FF);
        rd(16'h0011, 1'b0, 32'h00A5, "rd_out1");
        rd(16'h0014, 1'b0, 32'h0, "rd_unmap14");
        rd(16'h0011, 1'b0, 32'h00A5, "rd_out1b");
        rd(16'h0002, 1'b0, 32'h0, "rd_unmap02");
        rd(16'h0013, 1'b0, 32'h003C, "rd_out3");
        rd(16'h7777, 1'b0, 32'h0, "rd_unmap7777");
        wr(16'h0000, 16'hFFFF);
        chk("wr_ro", out_data, 32'h3C00_A5FF);
        wr(16'h0014, 16'hFFFF);
        chk("wr_unmap", out_data, 32'h3C00_A5FF);
        rd(16'h0000, 1'b0, 32'h0, "rd_ch0_after_wr");
        io_rd = 1'b1;
        wr(16'h0012, 16'h0077);
        io_rd = 1'b0;
        chk("wr_with_rd", out_data, 32'h3C77_A5FF);

        // 3: input channels and change flags
        in_data = {10'h3FF, 10'h000};
        step();
        rd(16'h0001, 1'b0, 32'h03FF, "rd_ch1");
        rd(16'h0030, 1'b1, 32'h0002, "flags_ch1");
        in_data = {10'h3FF, 10'h055};
        rd(16'h0030, 1'b1, 32'h0000, "flags_cleared");
        rd(16'h0030, 1'b1, 32'h0001, "flags_set_wins");
        rd(16'h0030, 1'b0, 32'h0000, "flags_final");
        rd(16'h0000, 1'b0, 32'h0055, "rd_ch0");

        // 4: glitches rejected, then one qualified press
        for (int i = 0; i < 5; i++) begin
            sw_in = 1'b1;
            repeat (3) step();
            sw_in = 1'b0;
            repeat (3) step();
            chk("glitch_sw", 32'(sw_state), 32'h0);
        end
        rd(16'h0021, 1'b1, 32'h0, "glitch_cnt");
        sw_in = 1'b1;
        rise_cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (sw_state == 1'b1 && rise_cyc == 0) rise_cyc = i;
        end
        chk("rise_latency", 32'(rise_cyc), 32'd6);
        rd(16'h0020, 1'b0, 32'h0001, "rd_swstate");
        sw_in = 1'b0;
        repeat (10) step();
        chk("fall_sw", 32'(sw_state), 32'h0);
        rd(16'h0021, 1'b1, 32'h0001, "cnt_one");

        // 5: counter wrap, then clear coincident with a rising edge
        for (int i = 0; i < 255; i++) press();
        rd(16'h0021, 1'b0, 32'h00FF, "cnt_255");
        press();
        rd(16'h0021, 1'b1, 32'h0000, "cnt_wrap");
        press();
        press();
        sw_in = 1'b1;
        repeat (5) step();
        chk("pre_edge_sw", 32'(sw_state), 32'h0);
        rd(16'h0021, 1'b1, 32'h0002, "clr_edge_rd");
        chk("clr_edge_sw", 32'(sw_state), 32'h1);
        rd(16'h0021, 1'b0, 32'h0001, "clr_edge_after");
        sw_in = 1'b0;
        repeat (10) step();
        rd(16'h0021, 1'b1, 32'h0001, "clr_edge_clear");

        // 6: reset during debounce with switch held
        sw_in = 1'b1;
        repeat (3) step();
        resetq = 1'b0;
        repeat (2) step();
        chk("rst_mid_sw", 32'(sw_state), 32'h0);
        resetq = 1'b1;
        rd(16'h0021, 1'b0, 32'h0, "rst_mid_cnt");
        repeat (3) step();
        chk("requal_early", 32'(sw_state), 32'h0);
        repeat (4) step();
        chk("requal_sw", 32'(sw_state), 32'h1);
        rd(16'h0021, 1'b1, 32'h0001, "requal_cnt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
